// File: rtl/fs_accel_pkg.sv
// Shared definitions for the accelerator stage controllers: layer types,
// stage state encodings and the POOL token payload.
package fs_accel_pkg;

    localparam logic [3:0] LAYER_CONV  = 4'd0;
    localparam logic [3:0] LAYER_DENSE = 4'd1;
    localparam logic [3:0] LAYER_MIXED = 4'd2;

    localparam logic [2:0] G_START  = 3'd0;
    localparam logic [2:0] G_QUANT  = 3'd1;
    localparam logic [2:0] G_POOL   = 3'd2;
    localparam logic [2:0] G_WAIT   = 3'd3;
    localparam logic [2:0] G_FINISH = 3'd4;

    typedef struct packed {
        logic        is_out_fin;
        logic [31:0] ps_addr;
        logic [31:0] o_addr;
        logic [3:0]  quant_sel;
    } pool_tok_t;

    function automatic logic layer_valid(input logic [3:0] typ);
        return (typ == LAYER_CONV) || (typ == LAYER_DENSE) || (typ == LAYER_MIXED);
    endfunction

endpackage

// File: rtl/fs_accel_pool_win_cnt.sv
// Max-pool window position counter: wraps after max(size,1) increments.
module fs_accel_pool_win_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic [W-1:0] size,
    output logic         first,
    output logic         last
);

    logic [W-1:0] cnt;
    logic [W-1:0] top;

    // A size of 0 behaves as a one-element window.
    assign top   = (size == '0) ? '0 : size - W'(1);
    assign first = (cnt == '0);
    assign last  = (cnt == top);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fs_accel_pool_ctrl.sv
// POOL stage controller: captures COMPS tokens, sequences quantizer and max-pool.
// FS_ACCEL_POOL_EN builds the G_POOL state and window counter; without it every finished output bypasses pooling.
module fs_accel_pool_ctrl
    import fs_accel_pkg::*;
#(
    parameter int QUANT_LAT  = 2,
    parameter int POOL_WIN_W = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enb,
    input  logic [3:0]            cfg_layer_typ,
    input  logic [POOL_WIN_W-1:0] cfg_pool_size,
    input  logic                  RDATA_rdy,
    input  logic                  RDATA_fin,
    input  logic                  COMPS_rdy,
    input  logic                  COMPS_fin,
    input  logic                  COMPS_is_out_fin,
    input  logic [31:0]           COMPS_ps_addr,
    input  logic [31:0]           COMPS_o_addr,
    input  logic [3:0]            COMPS_o_quant_sel,
    input  logic                  WBACK_rdy,
    input  logic                  WBACK_start,
    output logic                  quant_enb,
    output logic                  pool_enb,
    output logic                  pool_bps_write,
    output logic                  pool_cmp_write,
    output logic                  POOL_start,
    output logic                  POOL_rdy,
    output logic                  POOL_fin,
    output logic                  POOL_o_vld,
    output logic                  POOL_is_out_fin,
    output logic [31:0]           POOL_ps_addr,
    output logic [31:0]           POOL_o_addr,
    output logic [3:0]            POOL_o_quant_sel
);

    logic [2:0] state;
    logic [3:0] q_cnt;
    logic       typ_ok;
    logic       step;
    logic       pipe_adv;
    logic       q_done;
    logic       quant_to_pool;
    logic       o_vld;
    pool_tok_t  tok;

    // An unsupported layer type idles every output and freezes the FSM.
    assign typ_ok = layer_valid(cfg_layer_typ);
    assign step   = enb & typ_ok;

    assign POOL_start = typ_ok & (state == G_START);
    assign POOL_rdy   = typ_ok & (state == G_WAIT);
    assign POOL_fin   = typ_ok & (state == G_FINISH);
    assign quant_enb  = typ_ok & (state == G_QUANT);

    assign pipe_adv = enb & (RDATA_rdy | RDATA_fin) & (COMPS_rdy | COMPS_fin)
                    & (POOL_rdy | POOL_start) & (WBACK_rdy | WBACK_start);
    assign q_done   = (q_cnt == 4'(QUANT_LAT - 1));

`ifdef FS_ACCEL_POOL_EN
    logic win_first;
    logic win_last;

    assign pool_enb       = typ_ok & (state == G_POOL);
    assign pool_bps_write = pool_enb & win_first;
    assign pool_cmp_write = pool_enb & ~win_first;
    assign quant_to_pool  = (cfg_layer_typ != LAYER_DENSE);

    fs_accel_pool_win_cnt #(.W(POOL_WIN_W)) u_win_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (step & pool_enb),
        .size   (cfg_pool_size),
        .first  (win_first),
        .last   (win_last)
    );
`else
    logic unused_pool_size;

    assign unused_pool_size = ^cfg_pool_size;
    assign pool_enb         = 1'b0;
    assign pool_bps_write   = 1'b0;
    assign pool_cmp_write   = 1'b0;
    assign quant_to_pool    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= G_START;
            q_cnt <= '0;
            tok   <= '0;
            o_vld <= 1'b0;
        end else if (step) begin
            case (state)
                G_START, G_WAIT: begin
                    if (pipe_adv) begin
                        // pipe_adv implies COMPS_rdy whenever COMPS_fin is low.
                        if (COMPS_fin) begin
                            state <= G_FINISH;
                        end else begin
                            tok   <= {COMPS_is_out_fin, COMPS_ps_addr, COMPS_o_addr, COMPS_o_quant_sel};
                            o_vld <= 1'b0;
                            if (COMPS_is_out_fin) begin
                                state <= G_QUANT;
                                q_cnt <= '0;
                            end else begin
                                state <= G_WAIT;
                            end
                        end
                    end
                end
                G_QUANT: begin
                    if (q_done) begin
                        if (quant_to_pool) begin
                            state <= G_POOL;
                        end else begin
                            state <= G_WAIT;
                            o_vld <= 1'b1;
                        end
                    end else begin
                        q_cnt <= q_cnt + 4'd1;
                    end
                end
`ifdef FS_ACCEL_POOL_EN
                G_POOL: begin
                    state <= G_WAIT;
                    if (win_last) o_vld <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign POOL_o_vld       = o_vld;
    assign POOL_is_out_fin  = tok.is_out_fin;
    assign POOL_ps_addr     = tok.ps_addr;
    assign POOL_o_addr      = tok.o_addr;
    assign POOL_o_quant_sel = tok.quant_sel;

endmodule

// File: tb/tb_fs_accel_pool_ctrl.sv
// Self-checking bench for fs_accel_pool_ctrl: directed token table, corner sequences
// and a randomized token stream against a transaction-level model.
module tb_fs_accel_pool_ctrl;
    import fs_accel_pkg::*;

    localparam int QL = 2;
`ifdef FS_ACCEL_POOL_EN
    localparam bit POOL_EN = 1'b1;
`else
    localparam bit POOL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        enb;
    logic [3:0]  cfg_layer_typ;
    logic [2:0]  cfg_pool_size;
    logic        RDATA_rdy, RDATA_fin, COMPS_rdy, COMPS_fin, COMPS_is_out_fin;
    logic [31:0] COMPS_ps_addr, COMPS_o_addr;
    logic [3:0]  COMPS_o_quant_sel;
    logic        WBACK_rdy, WBACK_start;
    logic        quant_enb, pool_enb, pool_bps_write, pool_cmp_write;
    logic        POOL_start, POOL_rdy, POOL_fin, POOL_o_vld, POOL_is_out_fin;
    logic [31:0] POOL_ps_addr, POOL_o_addr;
    logic [3:0]  POOL_o_quant_sel;

    fs_accel_pool_ctrl #(.QUANT_LAT(QL), .POOL_WIN_W(3)) dut (
        .clk(clk), .resetn(resetn), .enb(enb),
        .cfg_layer_typ(cfg_layer_typ), .cfg_pool_size(cfg_pool_size),
        .RDATA_rdy(RDATA_rdy), .RDATA_fin(RDATA_fin),
        .COMPS_rdy(COMPS_rdy), .COMPS_fin(COMPS_fin),
        .COMPS_is_out_fin(COMPS_is_out_fin), .COMPS_ps_addr(COMPS_ps_addr),
        .COMPS_o_addr(COMPS_o_addr), .COMPS_o_quant_sel(COMPS_o_quant_sel),
        .WBACK_rdy(WBACK_rdy), .WBACK_start(WBACK_start),
        .quant_enb(quant_enb), .pool_enb(pool_enb),
        .pool_bps_write(pool_bps_write), .pool_cmp_write(pool_cmp_write),
        .POOL_start(POOL_start), .POOL_rdy(POOL_rdy), .POOL_fin(POOL_fin),
        .POOL_o_vld(POOL_o_vld), .POOL_is_out_fin(POOL_is_out_fin),
        .POOL_ps_addr(POOL_ps_addr), .POOL_o_addr(POOL_o_addr),
        .POOL_o_quant_sel(POOL_o_quant_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_pass = 0;
    int n_total = 0;
    int m_q, m_p, m_bps, m_cmp, m_lat;

    typedef struct {
        logic [3:0]  typ;
        logic        fin;
        logic [31:0] o_addr;
        int          q, p, bps, cmp, lat;
        logic        vld;
    } vec_t;
    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
    endtask

    task automatic load_token(input logic [3:0] typ, input logic fin, input logic [31:0] ps,
                              input logic [31:0] oa, input logic [3:0] qs);
        int w = 0;
        while (!(POOL_rdy || POOL_start) && w < 100) begin
            tick;
            w++;
        end
        chk("ready_before_load", 32'(POOL_rdy | POOL_start), 1);
        cfg_layer_typ     = typ;
        COMPS_rdy         = 1'b1;
        COMPS_fin         = 1'b0;
        COMPS_is_out_fin  = fin;
        COMPS_ps_addr     = ps;
        COMPS_o_addr      = oa;
        COMPS_o_quant_sel = qs;
        tick;
        // Scramble the payload inputs so a stray reload would show up.
        COMPS_rdy         = 1'b0;
        COMPS_ps_addr     = $urandom;
        COMPS_o_addr      = $urandom;
        COMPS_o_quant_sel = 4'($urandom);
        COMPS_is_out_fin  = 1'($urandom);
    endtask

    task automatic measure(input int stall);
        m_q = 0; m_p = 0; m_bps = 0; m_cmp = 0; m_lat = 0;
        while (!POOL_rdy && m_lat < 100) begin
            m_q   += int'(quant_enb);
            m_p   += int'(pool_enb);
            m_bps += int'(pool_bps_write);
            m_cmp += int'(pool_cmp_write);
            enb = (m_lat < stall) ? 1'b0 : 1'b1;
            tick;
            m_lat++;
        end
        enb = 1'b1;
    endtask

    task automatic check_tok(input string tag, input int q, input int p, input int bps,
                             input int cmp, input int lat, input logic vld, input logic fin,
                             input logic [31:0] ps, input logic [31:0] oa, input logic [3:0] qs);
        chk({tag, ".lat"}, 32'(m_lat), 32'(lat));
        chk({tag, ".quant_cycles"}, 32'(m_q), 32'(q));
        chk({tag, ".pool_cycles"}, 32'(m_p), 32'(p));
        chk({tag, ".bps_writes"}, 32'(m_bps), 32'(bps));
        chk({tag, ".cmp_writes"}, 32'(m_cmp), 32'(cmp));
        chk({tag, ".o_vld"}, 32'(POOL_o_vld), 32'(vld));
        chk({tag, ".is_out_fin"}, 32'(POOL_is_out_fin), 32'(fin));
        chk({tag, ".ps_addr"}, POOL_ps_addr, ps);
        chk({tag, ".o_addr"}, POOL_o_addr, oa);
        chk({tag, ".quant_sel"}, 32'(POOL_o_quant_sel), 32'(qs));
    endtask

    // Token-level reference: what one token should produce, given the window fill so far.
    function automatic void model(input logic [3:0] typ, input logic fin, input int size,
                                  inout int win, output int q, output int p, output int bps,
                                  output int cmp, output int lat, output logic vld);
        int n = (size == 0) ? 1 : size;
        q = 0; p = 0; bps = 0; cmp = 0; lat = 0; vld = 1'b0;
        if (fin) begin
            q = QL; lat = QL; vld = 1'b1;
            if (POOL_EN && typ != LAYER_DENSE) begin
                p   = 1;
                lat = QL + 1;
                bps = (win == 0) ? 1 : 0;
                cmp = 1 - bps;
                win = (win + 1) % n;
                vld = (win == 0);
            end
        end
    endfunction

    initial begin
        int q, p, bps, cmp, lat, win, size, w;
        logic vld;
        logic [3:0] typ;
        logic fin;
        logic [31:0] ps, oa;
        logic [3:0] qs;

        resetn = 1'b0; enb = 1'b1; cfg_layer_typ = LAYER_CONV; cfg_pool_size = 3'd4;
        RDATA_rdy = 1'b1; RDATA_fin = 1'b0; COMPS_rdy = 1'b0; COMPS_fin = 1'b0;
        COMPS_is_out_fin = 1'b0; COMPS_ps_addr = '0; COMPS_o_addr = '0; COMPS_o_quant_sel = '0;
        WBACK_rdy = 1'b1; WBACK_start = 1'b0;

        for (int i = 0; i < 4; i++) begin
            vecs[i] = '{typ: LAYER_CONV, fin: 1'b1, o_addr: 32'h10 + 32'(i), q: 2,
                        p: POOL_EN ? 1 : 0, bps: (POOL_EN && i == 0) ? 1 : 0,
                        cmp: (POOL_EN && i != 0) ? 1 : 0, lat: POOL_EN ? 3 : 2,
                        vld: POOL_EN ? (i == 3) : 1'b1};
        end
        vecs[4] = '{typ: LAYER_CONV, fin: 1'b0, o_addr: 32'h20, q: 0, p: 0, bps: 0, cmp: 0, lat: 0, vld: 1'b0};
        vecs[5] = '{typ: LAYER_DENSE, fin: 1'b1, o_addr: 32'h30, q: 2, p: 0, bps: 0, cmp: 0, lat: 2, vld: 1'b1};

        do_reset;
        chk("rst.POOL_start", 32'(POOL_start), 1);
        chk("rst.POOL_rdy", 32'(POOL_rdy), 0);
        chk("rst.POOL_fin", 32'(POOL_fin), 0);
        chk("rst.enables", 32'({quant_enb, pool_enb, pool_bps_write, pool_cmp_write}), 0);
        chk("rst.o_vld", 32'(POOL_o_vld), 0);
        chk("rst.payload", POOL_ps_addr | POOL_o_addr | 32'(POOL_o_quant_sel) | 32'(POOL_is_out_fin), 0);

        cfg_layer_typ = 4'd7;
        #1;
        chk("badtyp.POOL_start", 32'(POOL_start), 0);
        COMPS_rdy = 1'b1; COMPS_is_out_fin = 1'b1; COMPS_o_addr = 32'hABCD;
        tick;
        COMPS_rdy = 1'b0; cfg_layer_typ = LAYER_CONV;
        #1;
        chk("badtyp.frozen_start", 32'(POOL_start), 1);
        chk("badtyp.no_load", POOL_o_addr, 0);

        for (int i = 0; i < 6; i++) begin
            load_token(vecs[i].typ, vecs[i].fin, 32'h1000 + 32'(i), vecs[i].o_addr, 4'(i));
            measure(0);
            check_tok($sformatf("vec%0d", i), vecs[i].q, vecs[i].p, vecs[i].bps, vecs[i].cmp,
                      vecs[i].lat, vecs[i].vld, vecs[i].fin, 32'h1000 + 32'(i), vecs[i].o_addr, 4'(i));
        end

        // enb low for 3 cycles inside G_QUANT; window is empty again here.
        load_token(LAYER_CONV, 1'b1, 32'h2000, 32'h40, 4'd9);
        measure(3);
        check_tok("stall", QL + 3, POOL_EN ? 1 : 0, POOL_EN ? 1 : 0, 0, QL + 3 + (POOL_EN ? 1 : 0),
                  !POOL_EN, 1'b1, 32'h2000, 32'h40, 4'd9);

        // Reset while the second window element is being pooled.
        load_token(LAYER_CONV, 1'b1, 32'h2100, 32'h41, 4'd3);
        w = 0;
        while (!(POOL_EN ? pool_enb : quant_enb) && w < 50) begin
            tick;
            w++;
        end
        chk("midrst.reached", 32'(POOL_EN ? pool_enb : quant_enb), 1);
        resetn = 1'b0;
        tick;
        chk("midrst.POOL_start", 32'(POOL_start), 1);
        chk("midrst.enables", 32'({quant_enb, pool_enb, pool_bps_write, pool_cmp_write}), 0);
        chk("midrst.payload", POOL_ps_addr | POOL_o_addr | 32'(POOL_o_quant_sel) | 32'(POOL_is_out_fin), 0);
        chk("midrst.o_vld", 32'(POOL_o_vld), 0);
        resetn = 1'b1;
        load_token(LAYER_CONV, 1'b1, 32'h2200, 32'h42, 4'd5);
        measure(0);
        check_tok("postrst", QL, POOL_EN ? 1 : 0, POOL_EN ? 1 : 0, 0, QL + (POOL_EN ? 1 : 0),
                  !POOL_EN, 1'b1, 32'h2200, 32'h42, 4'd5);

        do_reset;
        size = $urandom_range(0, 7);
        cfg_pool_size = 3'(size);
        win = 0;
        for (int i = 0; i < 40; i++) begin
            typ = 4'($urandom_range(0, 2));
            fin = 1'($urandom_range(0, 1));
            ps  = $urandom;
            oa  = $urandom;
            qs  = 4'($urandom);
            model(typ, fin, size, win, q, p, bps, cmp, lat, vld);
            load_token(typ, fin, ps, oa, qs);
            measure(0);
            check_tok($sformatf("rnd%0d", i), q, p, bps, cmp, lat, vld, fin, ps, oa, qs);
        end

        // COMPS_fin together with COMPS_rdy while waiting: finish wins, no load.
        load_token(LAYER_MIXED, 1'b0, 32'h3000, 32'h50, 4'd6);
        measure(0);
        chk("fin.in_wait", 32'(POOL_rdy), 1);
        COMPS_fin = 1'b1; COMPS_rdy = 1'b1;
        COMPS_o_addr = 32'hFFFF; COMPS_ps_addr = 32'hEEEE;
        tick;
        chk("fin.POOL_fin", 32'(POOL_fin), 1);
        chk("fin.POOL_rdy", 32'(POOL_rdy), 0);
        chk("fin.o_addr", POOL_o_addr, 32'h50);
        COMPS_fin = 1'b0;
        repeat (3) tick;
        chk("fin.held", 32'(POOL_fin), 1);
        chk("fin.ps_addr", POOL_ps_addr, 32'h3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fs_accel_pool_ctrl.md
# fs_accel_pool_ctrl

Pipeline-stage controller for the POOL stage of the accelerator datapath, sitting directly downstream of the COMPS stage and upstream of WBACK. It captures each COMPS token (addresses, quant select, output-finished flag) on the global pipeline advance. For finished outputs it sequences the quantizer and then the max-pool window registers. It reports `POOL_start`/`POOL_rdy`/`POOL_fin` back into the shared handshake.

## Interface
- `QUANT_LAT`, 2: number of cycles `quant_enb` is held per finished output; legal range 1..15.
- `POOL_WIN_W`, 3: width of `cfg_pool_size` and of the window counter.

- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `enb` in 1: global enable; low freezes all state.
- `cfg_layer_typ` in 4: 0 = CONV, 1 = DENSE, 2 = MIXED; other values give idle outputs and a frozen FSM.
- `cfg_pool_size` in POOL_WIN_W: number of outputs per pool window; 0 is treated as 1.
- `RDATA_rdy`, `RDATA_fin` in 1 each: upstream-most stage handshake.
- `COMPS_rdy`, `COMPS_fin` in 1 each: COMPS handshake.
- `COMPS_is_out_fin` in 1, `COMPS_ps_addr` in 32, `COMPS_o_addr` in 32, `COMPS_o_quant_sel` in 4: COMPS token payload.
- `WBACK_rdy`, `WBACK_start` in 1 each: WBACK handshake.
- `quant_enb` out 1: quantizer enable.
- `pool_enb` out 1: pool register enable.
- `pool_bps_write` out 1: load the window register with the quantized value (first element of a window).
- `pool_cmp_write` out 1: max-compare-and-write into the window register.
- `POOL_start`, `POOL_rdy`, `POOL_fin` out 1 each: stage handshake.
- `POOL_o_vld` out 1: current token carries a completed pooled output for WBACK.
- `POOL_is_out_fin` out 1, `POOL_ps_addr` out 32, `POOL_o_addr` out 32, `POOL_o_quant_sel` out 4: registered payload.

## Operation
- `pipe_adv` = `enb` & (`RDATA_rdy`|`RDATA_fin`) & (`COMPS_rdy`|`COMPS_fin`) & (`POOL_rdy`|`POOL_start`) & (`WBACK_rdy`|`WBACK_start`).
- The payload register loads on `pipe_adv` & `COMPS_rdy`.
- FSM states:
  - G_START: `POOL_start`=1.
  - G_QUANT: `quant_enb`=1.
  - G_POOL: `pool_enb`=1.
  - G_WAIT: `POOL_rdy`=1.
  - G_FINISH: `POOL_fin`=1.
- Transitions out of G_START and G_WAIT, evaluated on `pipe_adv`:
  - If `COMPS_fin`: go to G_FINISH; no load.
  - Else if `COMPS_is_out_fin`: go to G_QUANT and clear the quant counter.
  - Else: go to (or stay in) G_WAIT; the token is a partial sum and `POOL_o_vld`=0.
- G_QUANT: the counter increments each enabled cycle. After `QUANT_LAT` cycles the FSM goes to G_POOL for CONV/MIXED, or to G_WAIT for DENSE. For DENSE, `POOL_o_vld` is set on that same transition.
- G_POOL: lasts exactly one cycle, then the FSM goes to G_WAIT.
  - If `win_cnt`==0, assert `pool_bps_write`; otherwise assert `pool_cmp_write`.
  - If `win_cnt`==max(`cfg_pool_size`,1)-1: set `POOL_o_vld` and wrap `win_cnt` to 0. Otherwise increment `win_cnt`.
- G_FINISH: terminal; held until reset.
- `POOL_o_vld` is cleared on every payload load.
- `win_cnt` persists across tokens and is cleared only by reset.

## Timing
- Reset (synchronous, `resetn`=0): state G_START, counters 0, and all registered outputs 0 (`POOL_o_vld`, `POOL_is_out_fin`, `POOL_ps_addr`, `POOL_o_addr`, `POOL_o_quant_sel`). Combinational outputs follow from G_START: `POOL_start`=1, all others 0.
- Reset asserted mid-token aborts the token and the partial window with no further enables.
- Handshake outputs are combinational from the state. Payload and `POOL_o_vld` are registered.
- Load-to-`POOL_rdy` latency: CONV/MIXED finished output = `QUANT_LAT`+1 cycles after the load edge; DENSE finished output = `QUANT_LAT`; partial sum = 0 (rdy stays high).
- `enb`=0 freezes the FSM, the counters and the payload; combinational outputs keep reflecting the frozen state.
- `COMPS_rdy` and `COMPS_fin` both high at `pipe_adv`: fin wins.

## Configuration
- `FS_ACCEL_POOL_EN` defined: behaviour as above.
- `FS_ACCEL_POOL_EN` undefined:
  - G_POOL and the window counter are not built.
  - G_QUANT always exits to G_WAIT and sets `POOL_o_vld` for every layer type.
  - `pool_enb`, `pool_bps_write` and `pool_cmp_write` are tied to 0.

## Structure
- Shared package `fs_accel_pkg` holds the layer-type constants (CONV/DENSE/MIXED) and the stage state encodings (G_START..G_FINISH) used by every stage controller.
- One sub-module, `fs_accel_pool_win_cnt`: POOL_WIN_W-bit wrap counter with inputs inc and size, output last.

## Test plan
- CONV, `QUANT_LAT`=2, `cfg_pool_size`=4, four finished tokens with `o_addr` 0x10..0x13: each token gives `quant_enb` for 2 cycles then `pool_enb` for 1; `pool_bps_write` on the 1st, `pool_cmp_write` on the 2nd–4th; `POOL_o_vld`=1 only with `POOL_o_addr`=0x13.
- Partial-sum token (`COMPS_is_out_fin`=0): no `quant_enb`/`pool_enb`; `POOL_rdy` continuous; `POOL_ps_addr` equals the captured value; `POOL_o_vld`=0.
- DENSE finished token: `quant_enb` for 2 cycles, no `pool_enb`, `POOL_o_vld`=1, `POOL_rdy` 2 cycles after load.
- `enb` dropped for 3 cycles inside G_QUANT: the quant pulse is stretched by exactly 3 cycles; the payload is unchanged.
- `COMPS_fin` with `pipe_adv` while in G_WAIT: `POOL_fin`=1 next cycle and held; the payload is unchanged.
- `resetn`=0 for one edge in G_POOL mid-window: next cycle `POOL_start`=1, `win_cnt`=0, all payload 0; the next window starts with `pool_bps_write`.
